spi_cmd_log: RTL and testbench
==============================

Name: spi_cmd_log

Overview:
- Downstream consumer of the uspispy logical command interface (clk domain).
- Each spi_cmd_strobe is captured with a microsecond timestamp into a FIFO.
- The picosoc firmware drains the FIFO over iomem, so back-to-back commands are no longer lost the way they are with the single-entry latest-command registers.
- Sits on the iomem bus beside the uspy register window; top decodes its window and drives sel.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
- TS_WIDTH, 24, timestamp width in microsecond ticks.
- PRESCALE, 16, clk cycles per timestamp tick (16 MHz clk gives 1 us).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- spi_cmd_strobe  input  1  one-cycle pulse: new command valid
- spi_cmd  input  8  SPI opcode
- spi_addr  input  32  command address
- spi_len  input  12  transfer length
- sel  input  1  iomem select for this window (iomem_valid already qualified)
- addr  input  8  iomem byte offset
- wstrb  input  4  iomem write strobes (0 = read)
- wdata  input  32  iomem write data
- rdata  output  32  iomem read data
- ready  output  1  iomem ready pulse
- irq  output  1  level: FIFO non-empty and CTRL.irq_en

Behaviour:
- Reset (async):
  - FIFO empty, count 0, overflow 0, timestamp 0, prescaler 0.
  - CTRL.enable=1, irq_en=0.
  - rdata=0, ready=0, irq=0.
- Timestamp:
  - Prescaler counts 0..PRESCALE-1; at wrap, ts increments.
  - ts wraps modulo 2**TS_WIDTH.
- Capture:
  - On spi_cmd_strobe with enable=1, push {ts, cmd, addr, len} (76 bits).
  - ts is the value in the strobe cycle.
- Full:
  - Push is dropped; overflow count increments, saturating at 0xFFFF.
  - FIFO contents are unchanged.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, the pop frees the slot, so the push succeeds.
- Pop while empty: no effect.
- iomem handshake:
  - ready is registered and asserts for one cycle, the cycle after sel is seen with ready=0. It deasserts the next cycle.
  - Register side effects happen only in the cycle ready asserts, exactly once per transaction.
  - rdata is valid while ready=1 and is 0 otherwise.
- Register map:
  - 0x00 STATUS (RO): [7:0] count, [8] empty, [9] full, [31:16] overflow.
  - 0x04 HEAD_CMD (RO): {ts[23:0], cmd}.
  - 0x08 HEAD_ADDR (RO): addr.
  - 0x0C HEAD_LEN (RO): {20'h0, len}.
  - 0x10 POP: write with any wstrb pops the head entry; reads return 0.
  - 0x14 CTRL (RW): [0] enable, [1] irq_en, [2] flush (write-1 self-clearing, reads 0), [15:8] filter code, [16] filter_en.
  - Other offsets: read 32'hDECAFBAD, writes ignored.
- Head reads:
  - On empty, head registers read 0.
  - Reads never pop; firmware reads HEAD_* then writes POP.
- Flush:
  - Empties the FIFO and clears overflow.
  - A strobe in the flush cycle is discarded and not counted as overflow.
- Disable: with enable=0, strobes are ignored and not counted.
- irq is combinational from registered state: !empty && irq_en.

Optional Feature:
- Macro: SPI_CMD_LOG_FILTER_EN.
- Defined: CTRL[16:8] implemented. When filter_en=1, strobes whose cmd equals the filter code are discarded (not pushed, not counted as overflow). Typical use is suppressing 0x05 status polls.
- Undefined: CTRL[16:8] read 0 and writes are ignored; every strobe is eligible.

Decomposition:
- Package spi_cmd_log_pkg holds:
  - register offsets (REG_STATUS..REG_CTRL)
  - CTRL bit indices
  - entry field widths and packed-entry width (76)
  - default read value 32'hDECAFBAD
- Sub-module spi_cmd_log_fifo: synchronous single-clock FIFO.
  - Parameterised width/depth.
  - push/pop/flush inputs; head data, count, empty, full outputs.
  - Pointers are DEPTH_LOG2+1 bits.
  - Top of spi_cmd_log handles the prescaler, filter, overflow and iomem decode.

Test Plan:
- Reset then 3 strobes (cmd 0x03/0x0B/0x02, addrs 0x1000/0x2000/0x3000, len 4) -> STATUS count=3, empty=0. HEAD_CMD low byte 0x03, HEAD_ADDR 0x1000. After POP, head is 0x0B/0x2000.
- 18 strobes with no pops (DEPTH_LOG2=4) -> count=16, full=1, overflow=2. The 16 entries are the first 16 in order.
- With FIFO full, strobe in the same cycle as a POP write's ready cycle -> count stays 16, overflow unchanged, newest entry is at the tail.
- Timestamp: strobe at clk cycle 160 and at cycle 480 after reset -> HEAD_CMD ts fields 10 and 30. Wrap check: force the ts limit and confirm the rollover to 0.
- Write CTRL flush with 5 entries and overflow=3, with a strobe in the same cycle -> count=0, overflow=0, empty=1. Reading CTRL returns flush=0. irq drops.
- With SPI_CMD_LOG_FILTER_EN, filter code 0x05 and filter_en=1: strobes 0x05,0x03,0x05 -> count=1, head cmd 0x03. Without the macro, CTRL reads [16:8]=0 and count=3.

Source files
------------

// File: rtl/spi_cmd_log_pkg.sv
// spi_cmd_log_pkg: register map, CTRL bit positions and FIFO entry layout
// shared by the SPI command log FIFO and its iomem front end.
package spi_cmd_log_pkg;

  // iomem register byte offsets
  localparam logic [7:0] REG_STATUS    = 8'h00;
  localparam logic [7:0] REG_HEAD_CMD  = 8'h04;
  localparam logic [7:0] REG_HEAD_ADDR = 8'h08;
  localparam logic [7:0] REG_HEAD_LEN  = 8'h0C;
  localparam logic [7:0] REG_POP       = 8'h10;
  localparam logic [7:0] REG_CTRL      = 8'h14;

  // CTRL bit indices
  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_FLUSH     = 2;
  localparam int CTRL_FCODE_LSB = 8;
  localparam int CTRL_FILT_EN   = 16;

  // entry field widths
  localparam int TS_W    = 24;
  localparam int CMD_W   = 8;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 12;
  localparam int ENTRY_W = TS_W + CMD_W + ADDR_W + LEN_W;  // 76

  // value returned for offsets outside the register map
  localparam logic [31:0] DEFAULT_RDATA = 32'hDECAFBAD;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } entry_t;

  // Pack one captured command into a FIFO entry.
  function automatic entry_t make_entry(input logic [TS_W-1:0] ts,
                                        input logic [CMD_W-1:0] cmd,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [LEN_W-1:0] len);
    entry_t e;
    e.ts   = ts;
    e.cmd  = cmd;
    e.addr = addr;
    e.len  = len;
    return e;
  endfunction

endpackage

// File: rtl/spi_cmd_log_fifo.sv
// spi_cmd_log_fifo: single-clock synchronous FIFO with extra-bit pointers.
// A pop frees a slot in the same cycle, so push+pop while full succeeds.
// Flush empties the FIFO and wins over any push in the same cycle.
module spi_cmd_log_fifo #(
  parameter int WIDTH      = 76,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic                do_pop_s;
  logic                do_push_s;

  assign count_o   = wptr_q - rptr_q;
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (count_o == DEPTH_CNT);
  assign head_o    = mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  assign do_push_s = push_i && !flush_i && (!full_o || do_pop_s);

  // Next pointer values: flush clears both, otherwise advance on push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array write port (contents need no reset, pointers guard reads).
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/spi_cmd_log.sv
// spi_cmd_log: timestamps every uspispy command strobe into a FIFO that
// picosoc firmware drains over iomem.  Register effects occur on the clock
// edge that raises ready, so each transaction acts exactly once.
// Optional: define SPI_CMD_LOG_FILTER_EN to implement the CTRL[16:8] opcode filter.
module spi_cmd_log
  import spi_cmd_log_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int TS_WIDTH   = 24,
  parameter int PRESCALE   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cmd_strobe,
  input  logic [7:0]  spi_cmd,
  input  logic [31:0] spi_addr,
  input  logic [11:0] spi_len,
  input  logic        sel,
  input  logic [7:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq
);

  localparam logic [15:0]         PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [15:0]         PRESC_ONE = 16'd1;
  localparam logic [TS_WIDTH-1:0] TS_ONE    = TS_WIDTH'(1);

  logic [15:0]         presc_q, presc_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                ready_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                enable_q, irq_en_q;
  logic [15:0]         ovf_q;
  logic                filt_en_s;
  logic [7:0]          filt_code_s;
  logic                access_s, wr_s, pop_s, ctrl_wr_s, flush_s;
  logic                push_req_s, drop_s;
  entry_t              head_s;
  logic [DEPTH_LOG2:0] count_s;
  logic                empty_s, full_s;
  logic                unused_s;

  assign unused_s  = ^wdata;
  assign access_s  = sel && !ready_q;
  assign wr_s      = access_s && (wstrb != 4'h0);
  assign pop_s     = wr_s && (addr == REG_POP);
  assign ctrl_wr_s = wr_s && (addr == REG_CTRL);
  assign flush_s   = ctrl_wr_s && wstrb[0] && wdata[CTRL_FLUSH];

  // A strobe is eligible when logging is enabled, no flush is underway and it is not filtered.
  assign push_req_s = spi_cmd_strobe && enable_q && !flush_s &&
                      !(filt_en_s && (spi_cmd == filt_code_s));
  // Full drops only when no pop frees a slot in the same cycle.
  assign drop_s     = push_req_s && full_s && !pop_s;

  spi_cmd_log_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .data_i  (make_entry(TS_W'(ts_q), spi_cmd, spi_addr, spi_len)),
    .head_o  (head_s),
    .count_o (count_s),
    .empty_o (empty_s),
    .full_o  (full_s)
  );

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign irq   = !empty_s && irq_en_q;

  // Prescaler and microsecond timestamp next state.
  always_comb begin
    presc_d = presc_q + PRESC_ONE;
    ts_d    = ts_q;
    if (presc_q >= PRESC_MAX) begin
      presc_d = '0;
      ts_d    = ts_q + TS_ONE;
    end else begin
      ts_d    = ts_q;
    end
  end

  // Prescaler and timestamp registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      ts_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ts_q    <= ts_d;
    end
  end

`ifdef SPI_CMD_LOG_FILTER_EN
  logic       filt_en_q;
  logic [7:0] filt_code_q;

  assign filt_en_s   = filt_en_q;
  assign filt_code_s = filt_code_q;

  // Opcode filter configuration (CTRL bytes 1 and 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_en_q   <= 1'b0;
      filt_code_q <= 8'h00;
    end else begin
      if (ctrl_wr_s && wstrb[1]) filt_code_q <= wdata[CTRL_FCODE_LSB +: 8];
      if (ctrl_wr_s && wstrb[2]) filt_en_q   <= wdata[CTRL_FILT_EN];
    end
  end
`else
  assign filt_en_s   = 1'b0;
  assign filt_code_s = 8'h00;
`endif

  // CTRL enable / irq_en bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b1;
      irq_en_q <= 1'b0;
    end else if (ctrl_wr_s && wstrb[0]) begin
      enable_q <= wdata[CTRL_ENABLE];
      irq_en_q <= wdata[CTRL_IRQ_EN];
    end
  end

  // Saturating overflow counter, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 16'h0000;
    end else if (flush_s) begin
      ovf_q <= 16'h0000;
    end else if (drop_s && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'h0001;
    end
  end

  // Read data mux; head registers read 0 while the FIFO is empty.
  always_comb begin
    rdata_d = DEFAULT_RDATA;
    case (addr)
      REG_STATUS:    rdata_d = {ovf_q, 6'h00, full_s, empty_s, 8'(count_s)};
      REG_HEAD_CMD:  rdata_d = empty_s ? 32'h0 : {head_s.ts, head_s.cmd};
      REG_HEAD_ADDR: rdata_d = empty_s ? 32'h0 : head_s.addr;
      REG_HEAD_LEN:  rdata_d = empty_s ? 32'h0 : {20'h00000, head_s.len};
      REG_POP:       rdata_d = 32'h0;
      REG_CTRL:      rdata_d = {15'h0000, filt_en_s, filt_code_s, 5'h00,
                                1'b0, irq_en_q, enable_q};
      default:       rdata_d = DEFAULT_RDATA;
    endcase
  end

  // iomem handshake: one-cycle ready pulse, rdata held at 0 outside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ready_q <= access_s;
      rdata_q <= access_s ? rdata_d : 32'h0;
    end
  end

endmodule

// File: tb/tb_spi_cmd_log.sv
// tb_spi_cmd_log: scoreboard bench for spi_cmd_log.  A second instance with
// a 4-bit timestamp and prescale 2 exercises timestamp rollover.
module tb_spi_cmd_log;
  import spi_cmd_log_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cmd_strobe = 1'b0;
  logic [7:0]  spi_cmd = 8'h00;
  logic [31:0] spi_addr = 32'h0;
  logic [11:0] spi_len = 12'h000;
  logic        sel = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata, rdata_w;
  logic        ready, ready_w, irq, irq_w;

  always #5 clk = ~clk;

  spi_cmd_log dut (
    .clk(clk), .reset(reset), .spi_cmd_strobe(spi_cmd_strobe), .spi_cmd(spi_cmd),
    .spi_addr(spi_addr), .spi_len(spi_len), .sel(sel), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .ready(ready), .irq(irq));

  spi_cmd_log #(.TS_WIDTH(4), .PRESCALE(2)) dut_w (
    .clk(clk), .reset(reset), .spi_cmd_strobe(spi_cmd_strobe), .spi_cmd(spi_cmd),
    .spi_addr(spi_addr), .spi_len(spi_len), .sel(sel), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata_w), .ready(ready_w), .irq(irq_w));

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Clock edges since reset release; equals the DUT timestamp source.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [23:0] ts;
    logic [23:0] ts_w;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [11:0] len;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_ovf = 16'h0;
  logic        m_en = 1'b1;
  logic        m_irq_en = 1'b0;
  logic        m_fen = 1'b0;
  logic [7:0]  m_fcode = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of one strobe sampled at the current edge (pop already applied).
  task automatic model_push(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l,
                            input bit flushed);
    exp_t e;
    if (!m_en || flushed) return;
    if (m_fen && (c == m_fcode)) return;
    if (sb.size() < 16) begin
      e.ts = 24'(cyc / 16); e.ts_w = 24'((cyc / 2) % 16);
      e.cmd = c; e.addr = a; e.len = l;
      sb.push_back(e);
    end else if (m_ovf != 16'hFFFF) begin
      m_ovf = m_ovf + 16'h1;
    end
  endtask

  // Drive a strobe for the next rising edge (caller is at a negedge).
  task automatic drive_strobe(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
    spi_cmd_strobe = 1'b1; spi_cmd = c; spi_addr = a; spi_len = l;
    model_push(c, a, l, 1'b0);
    @(posedge clk); #1;
    spi_cmd_strobe = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
    @(negedge clk);
    drive_strobe(c, a, l);
  endtask

  task automatic strobe_at(input int n, input logic [7:0] c, input logic [31:0] a);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
    drive_strobe(c, a, 12'h004);
  endtask

  // One iomem transaction, optionally with a strobe in the access cycle.
  task automatic bus(input logic [7:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     input bit stb, input logic [7:0] c,
                     output logic [31:0] rd, output logic [31:0] rdw);
    bit flushed = 1'b0;
    @(negedge clk);
    sel = 1'b1; addr = a; wstrb = ws; wdata = wd;
    if (stb) begin
      spi_cmd_strobe = 1'b1; spi_cmd = c; spi_addr = {24'h0, c}; spi_len = 12'h001;
    end
    if (ws != 4'h0 && a == REG_POP && sb.size() > 0) void'(sb.pop_front());
    if (ws != 4'h0 && a == REG_CTRL) begin
      if (wd[2]) begin sb.delete(); m_ovf = 16'h0; flushed = 1'b1; end
      m_en = wd[0]; m_irq_en = wd[1];
`ifdef SPI_CMD_LOG_FILTER_EN
      m_fcode = wd[15:8]; m_fen = wd[16];
`endif
    end
    if (stb) model_push(c, {24'h0, c}, 12'h001, flushed);
    @(posedge clk); #1;
    spi_cmd_strobe = 1'b0;
    chk("ready_pulse", {31'h0, ready}, 32'h1);
    rd = rdata; rdw = rdata_w;
    sel = 1'b0; wstrb = 4'h0;
    @(posedge clk); #1;
    chk("ready_idle", {31'h0, ready}, 32'h0);
    chk("rdata_idle", rdata, 32'h0);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] r, rw, e;
    e = {m_ovf, 6'h00, sb.size() == 16, sb.size() == 0, 8'(sb.size())};
    bus(REG_STATUS, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk({tag, "_status"}, r, e);
    chk({tag, "_status_w"}, rw, e);
  endtask

  task automatic check_head(input string tag);
    logic [31:0] r, rw;
    exp_t e;
    e = '{default: '0};
    if (sb.size() > 0) e = sb[0];
    bus(REG_HEAD_CMD, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk({tag, "_hcmd"}, r, {e.ts, e.cmd});
    chk({tag, "_hcmd_w"}, rw, {e.ts_w, e.cmd});
    bus(REG_HEAD_ADDR, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk({tag, "_haddr"}, r, e.addr);
    bus(REG_HEAD_LEN, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk({tag, "_hlen"}, r, {20'h0, e.len});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r, rw;
    bus(a, 4'hF, d, 1'b0, 8'h00, r, rw);
  endtask

  task automatic check_irq(input string tag);
    @(negedge clk);
    chk(tag, {31'h0, irq}, {31'h0, (sb.size() != 0) && m_irq_en});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sel = 1'b0; wstrb = 4'h0; spi_cmd_strobe = 1'b0;
    sb.delete(); m_ovf = 16'h0; m_en = 1'b1; m_irq_en = 1'b0; m_fen = 1'b0; m_fcode = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r, rw;

    // basic capture and pop
    do_reset();
    check_status("rst");
    check_head("rst");
    strobe(8'h03, 32'h1000, 12'h004);
    strobe(8'h0B, 32'h2000, 12'h004);
    strobe(8'h02, 32'h3000, 12'h004);
    check_status("three");
    check_head("three");
    wr(REG_POP, 32'h0);
    check_head("popped");

    // full, overflow, then pop+push in the same cycle
    do_reset();
    for (int i = 0; i < 18; i++) strobe(8'(8'h10 + i), 32'(32'h100 * i), 12'(i));
    check_status("full");
    bus(REG_POP, 4'hF, 32'h0, 1'b1, 8'hAA, r, rw);
    check_status("popstb");
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("drain%0d", i));
      wr(REG_POP, 32'h0);
    end
    check_status("drained");
    wr(REG_POP, 32'h0);
    check_status("pop_empty");

    // timestamps, including rollover in the 4-bit instance
    do_reset();
    strobe_at(30, 8'h21, 32'hA0);
    strobe_at(32, 8'h22, 32'hA1);
    strobe_at(160, 8'h23, 32'hA2);
    strobe_at(480, 8'h24, 32'hA3);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("ts%0d", i));
      wr(REG_POP, 32'h0);
    end

    // flush with pending entries, overflow and a concurrent strobe
    do_reset();
    wr(REG_CTRL, 32'h3);
    for (int i = 0; i < 19; i++) strobe(8'(i), 32'(i), 12'h001);
    for (int i = 0; i < 11; i++) wr(REG_POP, 32'h0);
    check_status("preflush");
    check_irq("irq_on");
    bus(REG_CTRL, 4'hF, 32'h7, 1'b1, 8'h55, r, rw);
    check_status("flushed");
    bus(REG_CTRL, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk("ctrl_rd", r, 32'h3);
    check_irq("irq_off");

    // opcode filter (inactive without the macro)
    do_reset();
    wr(REG_CTRL, 32'h0001_0501);
    strobe(8'h05, 32'h1, 12'h001);
    strobe(8'h03, 32'h2, 12'h001);
    strobe(8'h05, 32'h3, 12'h001);
    check_status("filter");
    check_head("filter");
    bus(REG_CTRL, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk("ctrl_filt", r, {15'h0, m_fen, m_fcode, 8'h01});

    // disable, unmapped and POP reads
    wr(REG_CTRL, 32'h4);
    strobe(8'h66, 32'h6, 12'h001);
    check_status("disabled");
    bus(8'h20, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk("unmapped", r, 32'hDECAFBAD);
    bus(REG_POP, 4'h0, 32'h0, 1'b0, 8'h00, r, rw);
    chk("pop_rd", r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
